// File: rtl/left_shift_unit.sv
// Iterative dynamic left shifter (dshl) with valid/ready on both sides.
// Optional macro LEFT_SHIFT_STEP4_EN lets the shift advance 4 bits per cycle when possible.
module left_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic [SHAMT_W-1:0]                  in_shamt,
  input  logic                                in_signed,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH+(2**SHAMT_W)-2:0]       out_data,
  output logic                                busy
);

  localparam int OUT_W = WIDTH + (2**SHAMT_W) - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [OUT_W-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;

  logic [OUT_W-1:0]   w_acc_next;
  logic [SHAMT_W-1:0] w_cnt_next;
  logic               w_accept;

  function automatic logic [OUT_W-1:0] extend_operand(input logic [WIDTH-1:0] d,
                                                      input logic             sg);
    logic [OUT_W-1:0] r;
    r = {{(OUT_W-WIDTH){sg & d[WIDTH-1]}}, d};
    return r;
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_acc;
  assign w_accept  = in_valid && in_ready;

`ifdef LEFT_SHIFT_STEP4_EN
  logic w_big_step;
  assign w_big_step = (int'(r_cnt) >= 4);
  assign w_acc_next = w_big_step ? (r_acc << 4) : (r_acc << 1);
  assign w_cnt_next = r_cnt - (w_big_step ? SHAMT_W'(4) : SHAMT_W'(1));
`else
  assign w_acc_next = r_acc << 1;
  assign w_cnt_next = r_cnt - SHAMT_W'(1);
`endif

  // Operands are captured only on the accept edge; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= extend_operand(in_data, in_signed);
            r_cnt   <= in_shamt;
            r_state <= (in_shamt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_left_shift_unit.sv
// Directed scoreboard bench for left_shift_unit (defaults; LEFT_SHIFT_STEP4_EN optional).
module tb_left_shift_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [30:0] out_data;

  int          checks = 0;
  int          errors = 0;
  logic [30:0] sb[$];
  logic [30:0] last_out = '0;

  left_shift_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [30:0] model(input logic [15:0] d, input logic [3:0] sh,
                                        input logic sg);
    logic [30:0] e;
    e = sg ? {{15{d[15]}}, d} : {15'd0, d};
    return e << sh;
  endfunction

  function automatic int exp_lat(input int n);
`ifdef LEFT_SHIFT_STEP4_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then advance past it.
  task automatic step();
    logic        in_fire;
    logic        out_fire;
    logic [30:0] e;
    in_fire  = in_valid && in_ready && reset;
    out_fire = out_valid && out_ready && reset;
    if (out_fire) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        last_out = out_data;
        check("out_data", 32'(out_data), 32'(e));
      end
    end
    if (in_fire) sb.push_back(model(in_data, in_shamt, in_signed));
    if (!reset) sb.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] sh,
                        input logic sg);
    int lat;
    in_data   = d;
    in_shamt  = sh;
    in_signed = sg;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = ~sh;
    in_signed = ~sg;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat(int'(sh))));
    step();
    check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [30:0] held;
    logic        seen;

    // Reset state, with a handshake offered that must be ignored.
    in_valid = 1'b1;
    in_data  = 16'h1111;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    run_op("u_1_sh15", 16'h0001, 4'd15, 1'b0);
    check("u_1_sh15_value", 32'(last_out), 32'h0000_8000);

    run_op("s_8000_sh3", 16'h8000, 4'd3, 1'b1);
    check("s_8000_sh3_value", {last_out[30], last_out}, 32'hFFFC_0000);

    run_op("u_abcd_sh0", 16'hABCD, 4'd0, 1'b0);
    check("u_abcd_sh0_value", 32'(last_out), 32'h0000_ABCD);

    run_op("s_7fff_sh15", 16'h7FFF, 4'd15, 1'b1);
    run_op("s_ffff_sh15", 16'hFFFF, 4'd15, 1'b1);
    check("s_ffff_sh15_value", 32'(last_out), 32'h7FFF_8000);
    run_op("u_ffff_sh15", 16'hFFFF, 4'd15, 1'b0);
    check("u_ffff_sh15_value", 32'(last_out), 32'h7FFF_8000);

    // Backpressure with a new operand waiting.
    out_ready = 1'b0;
    in_data   = 16'h1234;
    in_shamt  = 4'd2;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'(exp_lat(2)));
    held = out_data;
    check("bp_value", 32'(held), 32'h0000_48D0);
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    in_shamt = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data_stable", 32'(out_data), 32'(held));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_back_idle", 32'(in_ready), 32'd1);
    check("bp_valid_dropped", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("bp_new_accepted", 32'(busy), 32'd1);
    wait_valid(lat);
    check("bp_new_latency", 32'(lat), 32'(exp_lat(1)));
    step();
    check("bp_new_value", 32'(last_out), 32'h0000_01FE);

    // Reset in the middle of a shamt-10 shift.
    in_data   = 16'h0005;
    in_shamt  = 4'd10;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    run_op("u_3_sh13", 16'h0003, 4'd13, 1'b0);
    check("u_3_sh13_value", 32'(last_out), 32'h0000_6000);
    run_op("u_1_sh4", 16'h0001, 4'd4, 1'b0);
    check("u_1_sh4_value", 32'(last_out), 32'h0000_0010);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
